vga_scanout_pipe: RTL
=====================

// Module: vga_scanout_pipe
// PURPOSE
//  Parametrised VGA timing generator plus framebuffer scan-out. Generates hsync/vsync/de from
//  programmable timing, issues sequential reads to an external synchronous framebuffer RAM,
//  and re-aligns sync/de to the returned pixel data. Sits between the game renderer's frame
//  RAM and the VGA DAC pins; supersedes the fixed 640x480 display with in-module pixel array.
// PARAMETERS
//  H_ACTIVE 640 | H_FP 16 | H_SYNC 96 | H_BP 48 -- horizontal timing, pixels (total 800)
//  V_ACTIVE 480 | V_FP 10 | V_SYNC 2 | V_BP 29 -- vertical timing, lines (total 521)
//  SYNC_POL 0 -- sync active level (0 = active-low)
//  CW 4 -- bits per colour channel
//  SCALE_LOG2 0 -- pixel/line replication factor 2^SCALE_LOG2 (source = ACTIVE>>SCALE_LOG2)
//  RD_LAT 2 -- framebuffer read latency, cycles from fb_rd to fb_data valid (>=1)
//  ADDR_W 19 -- framebuffer address width
// PORTS
//  dclk      in   1       pixel clock
//  clr       in   1       asynchronous reset, active-high
//  fb_rd     out  1       framebuffer read strobe
//  fb_addr   out  ADDR_W  framebuffer word address
//  fb_data   in   3*CW    {r,g,b} pixel, valid RD_LAT cycles after fb_rd
//  hsync     out  1       horizontal sync
//  vsync     out  1       vertical sync
//  de        out  1       active video
//  red/green/blue out CW  colour outputs, 0 when de=0
//  frame_start out 1      one-cycle pulse, aligned to first active pixel of frame at pins
// BEHAVIOUR
//  - Counters hc 0..Htot-1, vc 0..Vtot-1; hc wraps -> vc++; vc wraps at Vtot-1 on hc wrap.
//    Line order: sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, +H_ACTIVE), front porch.
//    Same ordering vertically.
//  - Stage 0 (counter time): fb_rd = active(hc,vc); fb_addr = line_base + (x>>SCALE_LOG2).
//    line_base held in a register, no multiplier: cleared at vc=0; advanced by
//    H_ACTIVE>>SCALE_LOG2 at the end of each active line where ((y+1) mod 2^SCALE_LOG2)==0.
//    fb_addr holds its last value while fb_rd=0.
//  - hsync/vsync/de/frame_start delayed RD_LAT+1 cycles; rgb registered from fb_data,
//    so every pin output changes RD_LAT+1 cycles after the matching counter state.
//  - Reset (any time, incl. mid-frame): hc=vc=0, line_base=0, fb_rd=0, fb_addr=0, delay line
//    flushed to inactive; outputs hsync=vsync=~SYNC_POL, de=0, rgb=0, frame_start=0.
//    After release, first sync assertion at pins on cycle RD_LAT+1.
//  - Blanking: rgb forced 0 whenever delayed de=0, regardless of fb_data.
//  - Per frame exactly (H_ACTIVE*V_ACTIVE) fb_rd cycles; max address =
//    (H_ACTIVE*V_ACTIVE >> 2*SCALE_LOG2) - 1; no wrap within frame.
//  - Width rules: counters $clog2(total) bits; address arithmetic in ADDR_W bits, parameters
//    must satisfy source pixel count <= 2^ADDR_W (elaboration-time check).
// CONFIGURATION
//  VGA_TESTPAT_EN defined: extra input pat_sel (1 bit). pat_sel=1 -> fb_rd held 0, rgb at pins
//   = 8 colour bars, each H_ACTIVE/8 wide (white,yellow,cyan,green,magenta,red,blue,black),
//   all-ones = {CW{1}}; timing/latency unchanged. pat_sel sampled per cycle at stage 0.
//  Not defined: no pat_sel port, framebuffer scan-out only.
// STRUCTURE
//  vga_pkg: 640x480@60 timing constants, colour-bar table, active()/sync() helper functions.
//  Sub-module vga_delay_line (width, depth params; async clear to given reset value) for
//  sync/de/frame_start alignment.
// TESTING
//  1 clr pulsed at hc=300,vc=200 -> next cycle hsync=vsync=1, de=0, rgb=0; hsync low again
//    exactly RD_LAT+1=3 cycles after release.
//  2 free run 2 frames -> 800 cycles/line, hsync low 96 cycles, vsync low 2 lines of 521,
//    de high 640 cycles on 480 lines per frame.
//  3 SCALE_LOG2=0 -> fb_addr sequence 0..307199 once per frame, 307200 fb_rd pulses.
//  4 RAM model data = addr[11:0], RD_LAT=2 -> first de pixel rgb=000, 5th pixel rgb=004,
//    last pixel of line 0 = 27F; frame_start coincides with first de.
//  5 SCALE_LOG2=1 -> addr 0,0,1,1,...,319,319 on lines 0 and 1; line 2 starts at 320;
//    max addr 76799.
//  6 VGA_TESTPAT_EN, pat_sel=1 -> fb_rd=0; x=0 rgb=FFF, x=80 FF0, x=160 0FF, x=560 000.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared constants and helpers for the VGA scan-out pipeline:
//            640x480@60 reference timing, colour-bar table, and the
//            window/sync decode helpers used at counter time.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

   // 640x480@60 reference timing (pixels / lines)
   localparam int c_h_active_640 = 640;
   localparam int c_h_fp_640     = 16;
   localparam int c_h_sync_640   = 96;
   localparam int c_h_bp_640     = 48;
   localparam int c_v_active_480 = 480;
   localparam int c_v_fp_480     = 10;
   localparam int c_v_sync_480   = 2;
   localparam int c_v_bp_480     = 29;

   // Colour-bar table, {r,g,b} on/off flags, bar 0 is leftmost:
   // white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      case (idx)
         3'd0:    return 3'b111;
         3'd1:    return 3'b110;
         3'd2:    return 3'b011;
         3'd3:    return 3'b010;
         3'd4:    return 3'b101;
         3'd5:    return 3'b100;
         3'd6:    return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   // True when pos lies inside [start, start+len)
   function automatic logic active(input int pos, input int start, input int len);
      return (pos >= start) && (pos < start + len);
   endfunction

   // Sync occupies the first len positions of the line/frame
   function automatic logic sync(input int pos, input int len);
      return pos < len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : vga_delay_line
// Purpose  : Fixed-depth shift register used to carry sync/de/frame_start
//            sideband alongside the framebuffer read latency. Asynchronous
//            clear loads every stage with RST_VAL so a reset flushes all
//            in-flight state to inactive.
// Ports    : dclk   - clock
//            clr    - asynchronous clear, active-high
//            i_data - WIDTH-bit input
//            o_data - i_data delayed by DEPTH cycles
// Revision : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
)(
   input  logic             dclk,
   input  logic             clr,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   generate
      if (DEPTH < 1) begin : g_bad_depth
         $error("vga_delay_line: DEPTH must be >= 1");
      end
   endgenerate

   logic [WIDTH-1:0] r_pipe [DEPTH];

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RST_VAL;
      end else begin
         r_pipe[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_data = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_scanout_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout_pipe
// Purpose  : Programmable VGA timing generator with framebuffer scan-out.
//            Counter-time (stage 0) logic issues reads to an external
//            synchronous RAM; sync/de/frame_start are delayed to meet the
//            returned pixel, so every pin changes RD_LAT+1 cycles after the
//            counter state that produced it.
//            Optional build macro VGA_TESTPAT_EN adds input pat_sel which
//            replaces framebuffer data with 8 colour bars.
// Ports    : dclk, clr        - pixel clock, async active-high reset
//            fb_rd, fb_addr   - framebuffer read strobe / word address
//            fb_data          - {r,g,b} returned RD_LAT cycles after fb_rd
//            hsync, vsync, de - timing outputs (sync level SYNC_POL)
//            red/green/blue   - colour, forced 0 outside active video
//            frame_start      - pulse on first active pixel of a frame
//            pat_sel          - (VGA_TESTPAT_EN only) colour-bar select
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanout_pipe
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = c_h_active_640,
   parameter int H_FP       = c_h_fp_640,
   parameter int H_SYNC     = c_h_sync_640,
   parameter int H_BP       = c_h_bp_640,
   parameter int V_ACTIVE   = c_v_active_480,
   parameter int V_FP       = c_v_fp_480,
   parameter int V_SYNC     = c_v_sync_480,
   parameter int V_BP       = c_v_bp_480,
   parameter bit SYNC_POL   = 1'b0,
   parameter int CW         = 4,
   parameter int SCALE_LOG2 = 0,
   parameter int RD_LAT     = 2,
   parameter int ADDR_W     = 19
)(
   input  logic              dclk,
   input  logic              clr,
`ifdef VGA_TESTPAT_EN
   input  logic              pat_sel,
`endif
   output logic              fb_rd,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [3*CW-1:0]   fb_data,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [CW-1:0]     red,
   output logic [CW-1:0]     green,
   output logic [CW-1:0]     blue,
   output logic              frame_start
);

   localparam int c_htot    = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int c_vtot    = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int c_hw      = $clog2(c_htot);
   localparam int c_vw      = $clog2(c_vtot);
   localparam int c_hstart  = H_SYNC + H_BP;
   localparam int c_vstart  = V_SYNC + V_BP;
   localparam int c_src_w   = H_ACTIVE >> SCALE_LOG2;
   localparam longint c_src_pix = longint'(H_ACTIVE * V_ACTIVE) >> (2 * SCALE_LOG2);

   localparam logic [c_hw-1:0]   c_hlast    = c_hw'(c_htot - 1);
   localparam logic [c_vw-1:0]   c_vlast    = c_vw'(c_vtot - 1);
   localparam logic [c_hw-1:0]   c_hstart_t = c_hw'(c_hstart);
   localparam logic [c_vw-1:0]   c_vstart_t = c_vw'(c_vstart);
   localparam logic [c_hw-1:0]   c_hend_t   = c_hw'(c_hstart + H_ACTIVE - 1);
   localparam logic [c_vw-1:0]   c_ymask    = c_vw'((1 << SCALE_LOG2) - 1);
   localparam logic [ADDR_W-1:0] c_src_w_t  = ADDR_W'(c_src_w);

`ifdef VGA_TESTPAT_EN
   localparam int c_bar_w  = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   localparam int c_side_w = 8;
`else
   localparam int c_side_w = 4;
`endif

   generate
      if (c_src_pix > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
         $error("vga_scanout_pipe: source pixel count exceeds 2^ADDR_W");
      end
      if (RD_LAT < 1) begin : g_bad_rd_lat
         $error("vga_scanout_pipe: RD_LAT must be >= 1");
      end
   endgenerate

   // ---------------------------------------------------------------- counters
   logic [c_hw-1:0]   r_hc;
   logic [c_vw-1:0]   r_vc;
   logic [ADDR_W-1:0] r_line_base;
   logic [ADDR_W-1:0] r_addr_hold;

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (r_hc == c_hlast) begin
         r_hc <= '0;
         r_vc <= (r_vc == c_vlast) ? '0 : r_vc + c_vw'(1);
      end else begin
         r_hc <= r_hc + c_hw'(1);
      end
   end

   // ------------------------------------------------------- stage-0 decode
   logic              w_act, w_hs_on, w_vs_on, w_fs, w_pat, w_adv;
   logic [c_hw-1:0]   w_x;
   logic [c_vw-1:0]   w_y;
   logic [ADDR_W-1:0] w_addr;

   always_comb begin
      w_act   = active(int'(r_hc), c_hstart, H_ACTIVE) &&
                active(int'(r_vc), c_vstart, V_ACTIVE);
      w_hs_on = sync(int'(r_hc), H_SYNC);
      w_vs_on = sync(int'(r_vc), V_SYNC);
      w_fs    = (r_hc == c_hstart_t) && (r_vc == c_vstart_t);
      w_x     = r_hc - c_hstart_t;
      w_y     = r_vc - c_vstart_t;
      w_addr  = r_line_base + ADDR_W'(w_x >> SCALE_LOG2);
      // Last pixel of the final replicated copy of a source line
      w_adv   = w_act && (r_hc == c_hend_t) && (((w_y + c_vw'(1)) & c_ymask) == '0);
   end

`ifdef VGA_TESTPAT_EN
   logic [2:0] w_bar;
   assign w_pat = pat_sel;
   assign w_bar = 3'(int'(w_x) / c_bar_w);
`else
   assign w_pat = 1'b0;
`endif

   assign fb_rd   = w_act && !w_pat;
   assign fb_addr = fb_rd ? w_addr : r_addr_hold;

   // Running row base replaces a y*width multiply
   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         r_line_base <= '0;
         r_addr_hold <= '0;
      end else begin
         if (r_vc == '0)
            r_line_base <= '0;
         else if (w_adv)
            r_line_base <= r_line_base + c_src_w_t;
         if (fb_rd)
            r_addr_hold <= w_addr;
      end
   end

   // -------------------------------------------------- sideband alignment
   // Sideband is carried as active-high "on" flags so a flush reads as
   // blanking; polarity is applied at the pin register.
   logic [c_side_w-1:0] w_side, w_side_d;
   logic                w_d_hs, w_d_vs, w_d_de, w_d_fs;

`ifdef VGA_TESTPAT_EN
   logic       w_d_pat;
   logic [2:0] w_d_bar;
   logic [2:0] w_bar_f;
   assign w_side = {w_bar, w_pat, w_fs, w_act, w_vs_on, w_hs_on};
   assign {w_d_bar, w_d_pat, w_d_fs, w_d_de, w_d_vs, w_d_hs} = w_side_d;
   assign w_bar_f = bar_rgb(w_d_bar);
`else
   assign w_side = {w_fs, w_act, w_vs_on, w_hs_on};
   assign {w_d_fs, w_d_de, w_d_vs, w_d_hs} = w_side_d;
`endif

   // RD_LAT stages line the sideband up with fb_data; the pin register
   // below adds the final stage shared with the colour path.
   vga_delay_line #(
      .WIDTH   (c_side_w),
      .DEPTH   (RD_LAT),
      .RST_VAL ('0)
   ) u_side_dly (
      .dclk   (dclk),
      .clr    (clr),
      .i_data (w_side),
      .o_data (w_side_d)
   );

   // ---------------------------------------------------------- pin register
   logic          r_hsync, r_vsync, r_de, r_fs;
   logic [CW-1:0] r_red, r_green, r_blue;

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         r_hsync <= ~SYNC_POL;
         r_vsync <= ~SYNC_POL;
         r_de    <= 1'b0;
         r_fs    <= 1'b0;
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
      end else begin
         r_hsync <= w_d_hs ? SYNC_POL : ~SYNC_POL;
         r_vsync <= w_d_vs ? SYNC_POL : ~SYNC_POL;
         r_de    <= w_d_de;
         r_fs    <= w_d_fs;
         if (!w_d_de) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
`ifdef VGA_TESTPAT_EN
         end else if (w_d_pat) begin
            r_red   <= {CW{w_bar_f[2]}};
            r_green <= {CW{w_bar_f[1]}};
            r_blue  <= {CW{w_bar_f[0]}};
`endif
         end else begin
            r_red   <= fb_data[3*CW-1:2*CW];
            r_green <= fb_data[2*CW-1:CW];
            r_blue  <= fb_data[CW-1:0];
         end
      end
   end

   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign de          = r_de;
   assign frame_start = r_fs;
   assign red         = r_red;
   assign green       = r_green;
   assign blue        = r_blue;

endmodule
`default_nettype wire
